// File: rtl/wavetable_ram_arbiter.sv
// Shares the single-port wavetable RAM between VOICES round-robin readers and one
// config writer; read results return two cycles after the grant, tagged with the voice.
module wavetable_ram_arbiter #(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned VID_W    = 3,
    parameter int unsigned RAM_SIZE = 61
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VOICES-1:0]   rd_req,
    input  logic [VOICES*6-1:0] rd_addr,
    output logic [VOICES-1:0]   rd_gnt,
    output logic                rd_valid,
    output logic [VID_W-1:0]    rd_voice,
    output logic [7:0]          rd_left,
    output logic [7:0]          rd_right,
    output logic [7:0]          rd_factor,
    input  logic                wr_req,
    input  logic [5:0]          wr_addr,
    input  logic [7:0]          wr_left,
    input  logic [7:0]          wr_right,
    input  logic [7:0]          wr_factor,
    output logic                wr_ack,
    output logic                wr_err,
    output logic                ram_re,
    output logic [5:0]          ram_addr_r,
    input  logic [7:0]          ram_left_r,
    input  logic [7:0]          ram_right_r,
    input  logic [7:0]          ram_factor_r,
    output logic                ram_we,
    output logic [5:0]          ram_addr_w,
    output logic [7:0]          ram_left_w,
    output logic [7:0]          ram_right_w,
    output logic [7:0]          ram_factor_w
);

    localparam logic [6:0] RAM_LIMIT = 7'(RAM_SIZE);

    logic [VOICES-1:0] rd_gnt_q, rd_gnt_d;
    logic [VID_W-1:0]  ptr_q, ptr_d;
    logic              wr_ack_q, wr_err_q, wr_last_q;
    logic              ram_re_q, ram_we_q;
    logic [5:0]        ram_addr_r_q, ram_addr_w_q;
    logic [7:0]        ram_left_w_q, ram_right_w_q, ram_factor_w_q;
    logic              s1_valid_q, s1_oor_q, s2_valid_q, s2_oor_q;
    logic [VID_W-1:0]  s1_voice_q, s2_voice_q;
    logic              rd_valid_q;
    logic [VID_W-1:0]  rd_voice_q;
    logic [7:0]        rd_left_q, rd_right_q, rd_factor_q;

    logic [VOICES-1:0] rd_elig;
    logic              wr_elig, rd_found, do_wr, do_rd, rd_in_range, wr_in_range;
    logic [VID_W-1:0]  rd_sel;
    logic [5:0]        rd_sel_addr;

    always_comb begin
        // A requester whose grant is currently visible is masked so a late drop cannot double-grant
        rd_elig     = rd_req & ~rd_gnt_q;
        wr_elig     = wr_req & ~wr_ack_q;
        rd_found    = 1'b0;
        rd_sel      = '0;
        rd_sel_addr = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!rd_found && rd_elig[(32'(ptr_q) + i) % VOICES]) begin
                rd_found    = 1'b1;
                rd_sel      = VID_W'((32'(ptr_q) + i) % VOICES);
                rd_sel_addr = rd_addr[((32'(ptr_q) + i) % VOICES) * 6 +: 6];
            end
        end
        do_wr       = wr_elig && (!wr_last_q || !rd_found);
        do_rd       = rd_found && !do_wr;
        rd_in_range = {1'b0, rd_sel_addr} < RAM_LIMIT;
        wr_in_range = {1'b0, wr_addr} < RAM_LIMIT;
        rd_gnt_d    = '0;
        ptr_d       = ptr_q;
        if (do_rd) begin
            rd_gnt_d[rd_sel] = 1'b1;
            ptr_d            = VID_W'((32'(rd_sel) + 1) % VOICES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_gnt_q       <= '0;
            ptr_q          <= '0;
            wr_ack_q       <= 1'b0;
            wr_err_q       <= 1'b0;
            wr_last_q      <= 1'b0;
            ram_re_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_r_q   <= '0;
            ram_addr_w_q   <= '0;
            ram_left_w_q   <= '0;
            ram_right_w_q  <= '0;
            ram_factor_w_q <= '0;
            s1_valid_q     <= 1'b0;
            s1_oor_q       <= 1'b0;
            s1_voice_q     <= '0;
            s2_valid_q     <= 1'b0;
            s2_oor_q       <= 1'b0;
            s2_voice_q     <= '0;
            rd_valid_q     <= 1'b0;
            rd_voice_q     <= '0;
            rd_left_q      <= '0;
            rd_right_q     <= '0;
            rd_factor_q    <= '0;
        end else begin
            rd_gnt_q   <= rd_gnt_d;
            ptr_q      <= ptr_d;
            wr_last_q  <= do_wr;
            wr_ack_q   <= do_wr;
            wr_err_q   <= do_wr && !wr_in_range;
            ram_we_q   <= do_wr && wr_in_range;
            ram_re_q   <= do_rd && rd_in_range;
            s1_valid_q <= do_rd;
            if (do_wr && wr_in_range) begin
                ram_addr_w_q   <= wr_addr;
                ram_left_w_q   <= wr_left;
                ram_right_w_q  <= wr_right;
                ram_factor_w_q <= wr_factor;
            end
            if (do_rd) begin
                s1_voice_q <= rd_sel;
                s1_oor_q   <= !rd_in_range;
                if (rd_in_range) ram_addr_r_q <= rd_sel_addr;
            end
            // Stage 2 lines up with the RAM presenting data; the result register captures it
            s2_valid_q <= s1_valid_q;
            s2_voice_q <= s1_voice_q;
            s2_oor_q   <= s1_oor_q;
            rd_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                rd_voice_q  <= s2_voice_q;
                rd_left_q   <= s2_oor_q ? 8'h00 : ram_left_r;
                rd_right_q  <= s2_oor_q ? 8'h00 : ram_right_r;
                rd_factor_q <= s2_oor_q ? 8'h00 : ram_factor_r;
            end
        end
    end

    assign rd_gnt       = rd_gnt_q;
    assign rd_valid     = rd_valid_q;
    assign rd_voice     = rd_voice_q;
    assign rd_left      = rd_left_q;
    assign rd_right     = rd_right_q;
    assign rd_factor    = rd_factor_q;
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign ram_re       = ram_re_q;
    assign ram_addr_r   = ram_addr_r_q;
    assign ram_we       = ram_we_q;
    assign ram_addr_w   = ram_addr_w_q;
    assign ram_left_w   = ram_left_w_q;
    assign ram_right_w  = ram_right_w_q;
    assign ram_factor_w = ram_factor_w_q;

endmodule

// File: tb/tb_wavetable_ram_arbiter.sv
// Bench for wavetable_ram_arbiter: transaction table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_wavetable_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rd_req;
    logic [47:0] rd_addr;
    logic [7:0]  rd_gnt;
    logic        rd_valid;
    logic [2:0]  rd_voice;
    logic [7:0]  rd_left, rd_right, rd_factor;
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_left, wr_right, wr_factor;
    logic        wr_ack, wr_err, ram_re, ram_we;
    logic [5:0]  ram_addr_r, ram_addr_w;
    logic [7:0]  ram_left_r, ram_right_r, ram_factor_r;
    logic [7:0]  ram_left_w, ram_right_w, ram_factor_w;

    always #5 clk = ~clk;

    wavetable_ram_arbiter #(.VOICES(8), .VID_W(3), .RAM_SIZE(61)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_voice(rd_voice),
        .rd_left(rd_left), .rd_right(rd_right), .rd_factor(rd_factor),
        .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_left(wr_left), .wr_right(wr_right), .wr_factor(wr_factor),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .ram_re(ram_re), .ram_addr_r(ram_addr_r),
        .ram_left_r(ram_left_r), .ram_right_r(ram_right_r), .ram_factor_r(ram_factor_r),
        .ram_we(ram_we), .ram_addr_w(ram_addr_w),
        .ram_left_w(ram_left_w), .ram_right_w(ram_right_w), .ram_factor_w(ram_factor_w)
    );

    function automatic logic [23:0] pat(input int i);
        if (i == 5) return 24'h402211;
        return {8'(i * 7 + 3), 8'(i ^ 'h5A), 8'(i + 16)};
    endfunction

    // Single-port RAM: one-cycle read latency, entries stored as {factor, right, left}
    logic [23:0] ram_mem [64];
    logic [23:0] ram_rdata;
    bit          ram_loaded;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_we) ram_mem[ram_addr_w] <= {ram_factor_w, ram_right_w, ram_left_w};
            if (ram_re) ram_rdata <= ram_mem[ram_addr_r];
        end
    end
    assign ram_left_r   = ram_rdata[7:0];
    assign ram_right_r  = ram_rdata[15:8];
    assign ram_factor_r = ram_rdata[23:16];

    int tests = 0;
    int fails = 0;
    logic [23:0] shadow [64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {rd_gnt, rd_valid, rd_voice, rd_left, rd_right, rd_factor, wr_ack, wr_err,
                   ram_re, ram_addr_r, ram_we, ram_addr_w, ram_left_w, ram_right_w, ram_factor_w}, '0);
    endtask

    task automatic do_reset();
        rd_req = '0;
        wr_req = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
    endtask

    task automatic run_read(input int v, input logic [5:0] a, input logic exp_re, input logic [23:0] exp_d);
        rd_addr[v*6 +: 6] = a;
        rd_req[v] = 1'b1;
        @(negedge clk);
        chk("read_gnt", rd_gnt, 128'(8'h01 << v));
        chk("read_re", ram_re, exp_re);
        if (exp_re) chk("read_addr", ram_addr_r, a);
        chk("read_valid_early", rd_valid, 0);
        rd_req[v] = 1'b0;
        @(negedge clk);
        chk("read_gnt_pulse", rd_gnt, 0);
        chk("read_valid_early", rd_valid, 0);
        @(negedge clk);
        chk("read_valid", rd_valid, 1);
        chk("read_voice", rd_voice, v);
        chk("read_data", {rd_factor, rd_right, rd_left}, exp_d);
    endtask

    task automatic run_write(input logic [5:0] a, input logic [23:0] d, input logic exp_err);
        wr_addr = a;
        {wr_factor, wr_right, wr_left} = d;
        wr_req = 1'b1;
        @(negedge clk);
        chk("write_ack", wr_ack, 1);
        chk("write_err", wr_err, exp_err);
        chk("write_we", ram_we, !exp_err);
        chk("write_re_low", ram_re, 0);
        if (!exp_err) chk("write_port", {ram_addr_w, ram_factor_w, ram_right_w, ram_left_w}, {a, d});
        wr_req = 1'b0;
        if (!exp_err) shadow[a] = d;
        @(negedge clk);
        chk("write_ack_pulse", {wr_ack, wr_err, ram_we}, 0);
    endtask

    typedef struct {
        bit          is_wr;
        int          voice;
        logic [5:0]  addr;
        logic [23:0] data;   // write data, or expected read data
        logic        flag;   // expected wr_err, or expected ram_re
    } vec_t;
    vec_t tbl [12];

    // Reference model state for the random phase
    typedef struct { int due; int voice; logic [23:0] d; } res_t;
    res_t        q [$];
    int          ptr_m, mcyc;
    bit          wlast_m, eack, eerr, ere, ewe;
    logic [7:0]  eg;
    logic [5:0]  eaddr_r, eaddr_w;
    logic [23:0] ewd, last_d;

    task automatic model_step();
        logic [7:0] elig;
        logic [5:0] a;
        bit wel, found;
        int sel;
        elig  = rd_req & ~eg;
        wel   = wr_req && !eack;
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < 8; k++) begin
            if (!found && elig[(ptr_m + k) % 8]) begin
                found = 1'b1;
                sel   = (ptr_m + k) % 8;
            end
        end
        mcyc++;
        eg = '0; eack = 0; eerr = 0; ere = 0; ewe = 0;
        if (wel && (!wlast_m || !found)) begin
            eack = 1; wlast_m = 1;
            if (wr_addr < 61) begin
                ewe = 1; eaddr_w = wr_addr; ewd = {wr_factor, wr_right, wr_left};
                shadow[wr_addr] = ewd;
            end else eerr = 1;
        end else if (found) begin
            wlast_m = 0;
            eg[sel] = 1'b1;
            ptr_m   = (sel + 1) % 8;
            a       = rd_addr[sel*6 +: 6];
            if (a < 61) begin
                ere = 1; eaddr_r = a;
                q.push_back('{mcyc + 2, sel, shadow[a]});
            end else q.push_back('{mcyc + 2, sel, 24'h0});
        end else wlast_m = 0;
    endtask

    logic [7:0] g3 [8];
    bit         a3 [8];
    logic [7:0] g2 [5];
    bit         late [8];
    bit         wlate, exp_v;
    int         nack;

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = pat(i);
        rd_req = '0; rd_addr = '0; wr_req = 0; wr_addr = '0;
        wr_left = '0; wr_right = '0; wr_factor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0]  = '{1'b0, 2, 6'd5,  24'h402211, 1'b1};
        tbl[1]  = '{1'b1, 0, 6'd9,  24'hABCDEF, 1'b0};
        tbl[2]  = '{1'b0, 4, 6'd9,  24'hABCDEF, 1'b1};
        tbl[3]  = '{1'b1, 0, 6'd61, 24'h123456, 1'b1};
        tbl[4]  = '{1'b0, 6, 6'd63, 24'h000000, 1'b0};
        tbl[5]  = '{1'b0, 0, 6'd60, pat(60),    1'b1};
        tbl[6]  = '{1'b1, 0, 6'd60, 24'h5A5AA5, 1'b0};
        tbl[7]  = '{1'b0, 7, 6'd60, 24'h5A5AA5, 1'b1};
        tbl[8]  = '{1'b1, 0, 6'd0,  24'h010203, 1'b0};
        tbl[9]  = '{1'b0, 1, 6'd0,  24'h010203, 1'b1};
        tbl[10] = '{1'b0, 3, 6'd61, 24'h000000, 1'b0};
        tbl[11] = '{1'b1, 0, 6'd63, 24'h777777, 1'b1};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_wr) run_write(tbl[i].addr, tbl[i].data, tbl[i].flag);
            else              run_read(tbl[i].voice, tbl[i].addr, tbl[i].flag, tbl[i].data);
        end

        // Simultaneous write and read of the same entry: write wins, read sees new data
        wr_addr = 6'd20; {wr_factor, wr_right, wr_left} = 24'h778899; wr_req = 1;
        rd_addr[5*6 +: 6] = 6'd20; rd_req[5] = 1;
        @(negedge clk);
        chk("raw_ack", {wr_ack, rd_gnt}, {1'b1, 8'h00});
        wr_req = 0;
        @(negedge clk);
        chk("raw_gnt", {rd_gnt, ram_re, ram_addr_r}, {8'h20, 1'b1, 6'd20});
        rd_req[5] = 0;
        @(negedge clk);
        chk("raw_valid_early", rd_valid, 0);
        @(negedge clk);
        chk("raw_result", {rd_valid, rd_voice, rd_factor, rd_right, rd_left}, {1'b1, 3'd5, 24'h778899});
        shadow[20] = 24'h778899;

        // Round-robin from pointer 0 over voices 0, 3, 7
        do_reset();
        rd_addr[0 +: 6] = 6'd1; rd_addr[18 +: 6] = 6'd3; rd_addr[42 +: 6] = 6'd7;
        rd_req = 8'b1000_1001;
        g2 = '{8'h01, 8'h08, 8'h80, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_gnt", rd_gnt, g2[k]);
            chk("rr_valid", rd_valid, k >= 2);
            if (k >= 2) chk("rr_voice_data", {rd_voice, rd_factor, rd_right, rd_left},
                            {g2[k-2] == 8'h01 ? 3'd0 : (g2[k-2] == 8'h08 ? 3'd3 : 3'd7),
                             g2[k-2] == 8'h01 ? pat(1) : (g2[k-2] == 8'h08 ? pat(3) : pat(7))});
            rd_req = rd_req & ~rd_gnt;
        end

        // Writer contending with four continuously requesting voices
        do_reset();
        wr_addr = 6'd9; {wr_factor, wr_right, wr_left} = 24'hD91909; wr_req = 1;
        rd_addr[6 +: 6] = 6'd11; rd_addr[12 +: 6] = 6'd12;
        rd_addr[24 +: 6] = 6'd14; rd_addr[30 +: 6] = 6'd15;
        rd_req = 8'b0011_0110;
        g3 = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h10, 8'h20, 8'h02, 8'h04};
        a3 = '{1, 0, 1, 0, 0, 0, 0, 0};
        nack = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("cont_gnt", rd_gnt, g3[k]);
            chk("cont_ack", wr_ack, a3[k]);
            chk("cont_re_we_excl", ram_re & ram_we, 0);
            if (wr_ack) begin
                nack++;
                if (nack == 1) begin
                    wr_addr = 6'd10; {wr_factor, wr_right, wr_left} = 24'hDA1A0A;
                end else wr_req = 0;
            end
        end
        rd_req = '0; wr_req = 0;
        repeat (4) @(negedge clk);
        shadow[9] = 24'hD91909; shadow[10] = 24'hDA1A0A;
        run_read(3, 6'd9,  1'b1, 24'hD91909);
        run_read(3, 6'd10, 1'b1, 24'hDA1A0A);

        // Reset right after a grant: stale result dropped, search restarts at voice 0
        run_read(5, 6'd2, 1'b1, pat(2));
        rd_addr[6 +: 6] = 6'd4; rd_addr[36 +: 6] = 6'd8;
        rd_req = 8'b0100_0010;
        @(negedge clk);
        chk("rst_pre_gnt", rd_gnt, 8'h40);
        rst_n = 0;
        #1 check_all_zero("rst_async_clear");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1;
        @(negedge clk);
        chk("rst_regnt_first", {rd_gnt, rd_valid}, {8'h02, 1'b0});
        rd_req[1] = 0;
        @(negedge clk);
        chk("rst_regnt_second", {rd_gnt, rd_valid}, {8'h40, 1'b0});
        rd_req[6] = 0;
        @(negedge clk);
        chk("rst_result1", {rd_valid, rd_voice, rd_factor, rd_right, rd_left}, {1'b1, 3'd1, pat(4)});
        @(negedge clk);
        chk("rst_result2", {rd_valid, rd_voice, rd_factor, rd_right, rd_left}, {1'b1, 3'd6, pat(8)});

        // Pointer at 7 (last grant was voice 6): voice 7 first, then wrap to voice 0
        rd_addr[42 +: 6] = 6'd30; rd_addr[0 +: 6] = 6'd31;
        rd_req = 8'b1000_0001;
        @(negedge clk);
        chk("wrap_gnt7", rd_gnt, 8'h80);
        rd_req[7] = 0;
        @(negedge clk);
        chk("wrap_gnt0", rd_gnt, 8'h01);
        rd_req[0] = 0;
        @(negedge clk);
        chk("wrap_result7", {rd_valid, rd_voice, rd_factor, rd_right, rd_left}, {1'b1, 3'd7, pat(30)});
        @(negedge clk);
        chk("wrap_result0", {rd_valid, rd_voice, rd_factor, rd_right, rd_left}, {1'b1, 3'd0, pat(31)});

        // Randomized traffic against the reference model
        do_reset();
        ptr_m = 0; mcyc = 0; wlast_m = 0; eg = '0; eack = 0; eerr = 0;
        ere = 0; ewe = 0; eaddr_r = '0; eaddr_w = '0; ewd = '0; last_d = '0;
        q.delete();
        for (int v = 0; v < 8; v++) late[v] = 0;
        wlate = 0;
        model_step();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_gnt", rd_gnt, eg);
            chk("rnd_wr", {wr_ack, wr_err, ram_we, ram_re}, {eack, eerr, ewe, ere});
            if (ere) chk("rnd_addr_r", ram_addr_r, eaddr_r);
            if (ewe) chk("rnd_wport", {ram_addr_w, ram_factor_w, ram_right_w, ram_left_w}, {eaddr_w, ewd});
            exp_v = (q.size() > 0) && (q[0].due == mcyc);
            chk("rnd_valid", rd_valid, exp_v);
            if (exp_v) begin
                chk("rnd_voice", rd_voice, q[0].voice);
                last_d = q[0].d;
                void'(q.pop_front());
            end
            chk("rnd_data", {rd_factor, rd_right, rd_left}, last_d);
            for (int v = 0; v < 8; v++) begin
                if (late[v]) begin
                    rd_req[v] = 0; late[v] = 0;
                end else if (rd_req[v] && rd_gnt[v]) begin
                    if ($urandom % 2 == 0) rd_req[v] = 0; else late[v] = 1;
                end else if (!rd_req[v] && $urandom % 4 == 0) begin
                    rd_req[v] = 1;
                    rd_addr[v*6 +: 6] = ($urandom % 8 == 0) ? 6'(61 + $urandom % 3) : 6'($urandom % 61);
                end
            end
            if (wlate) begin
                wr_req = 0; wlate = 0;
            end else if (wr_req && wr_ack) begin
                if ($urandom % 2 == 0) wr_req = 0; else wlate = 1;
            end else if (!wr_req && $urandom % 5 == 0) begin
                wr_req  = 1;
                wr_addr = ($urandom % 8 == 0) ? 6'(61 + $urandom % 3) : 6'($urandom % 61);
                {wr_factor, wr_right, wr_left} = 24'($urandom);
            end
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wavetable_ram_arbiter.md
Name: wavetable_ram_arbiter

Overview:
Sequencer and arbiter that shares the single-port 61-entry wavetable RAM between VOICES voice engines, which issue reads, and one configuration writer, which loads entries. It issues at most one RAM operation per cycle and never asserts re and we together. Reads are granted round-robin. Writes are guaranteed at least every other cycle under contention. Read data is returned tagged with the voice ID.

Parameters:
VOICES, 8, number of read requesters (2..16)
VID_W, 3, voice ID width, equal to ceil(log2(VOICES))
RAM_SIZE, 61, valid entry count; addresses at or above this are out of range

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rd_req  in  VOICES  per-voice read request, level, held until granted
rd_addr  in  VOICES*6  per-voice entry index; voice v uses bits [6v+5:6v]
rd_gnt  out  VOICES  one-hot one-cycle pulse, the request is accepted
rd_valid  out  1  one-cycle pulse, read result present
rd_voice  out  VID_W  voice ID of the current result
rd_left, rd_right, rd_factor  out  8 each  result fields
wr_req  in  1  write request, level, held until acknowledged
wr_addr  in  6  entry index to write
wr_left, wr_right, wr_factor  in  8 each  write data
wr_ack  out  1  one-cycle pulse, the write is accepted
wr_err  out  1  pulse together with wr_ack when wr_addr >= RAM_SIZE
ram_re  out  1  RAM read enable
ram_addr_r  out  6  RAM read address
ram_left_r, ram_right_r, ram_factor_r  in  8 each  RAM read data, valid one cycle after ram_re
ram_we  out  1  RAM write enable
ram_addr_w  out  6  RAM write address
ram_left_w, ram_right_w, ram_factor_w  out  8 each  RAM write data

Behaviour:
- All outputs are registered. Reset values:
  - All outputs 0.
  - Round-robin pointer = 0.
  - wr_last = 0.
  - In-flight pipeline tags cleared.
- Eligibility, evaluated every cycle:
  - Voice v is eligible when rd_req[v]=1 and rd_gnt[v] is not currently high. This masking prevents a double grant while the requester drops its request.
  - The writer is eligible when wr_req=1 and wr_ack is not currently high.
- Issue decision at each clock edge, priority in this order:
  1. The writer is eligible and wr_last=0: issue a write.
  2. Any voice is eligible: issue a read.
  3. The writer is eligible: issue a write.
  4. Otherwise: idle.
- wr_last is set to 1 when a write is issued, otherwise cleared to 0. Consequence: under continuous contention, writes and reads alternate W,R,W,R.
- Read selection: the first eligible voice found searching upward from the pointer, with modulo-VOICES wrap. After a grant the pointer becomes (granted+1) mod VOICES. The pointer is unchanged when no read is issued.
- Read issue: in the cycle after the decision edge, rd_gnt[v]=1.
  - In range: ram_re=1 and ram_addr_r=rd_addr[v].
  - Out of range (addr >= RAM_SIZE): ram_re stays 0.
- Read return:
  - In range: the RAM presents data the next cycle. The controller registers it, so rd_valid=1 with rd_voice=v two cycles after rd_gnt.
  - Out of range: the same timing applies, but the data fields are 0x00.
  - Total latency from the first visible rd_req cycle to rd_valid is 3 cycles. Back-to-back reads produce back-to-back rd_valid pulses.
  - rd_left, rd_right and rd_factor hold their last value when rd_valid=0.
- Write issue: in the cycle after the decision edge, wr_ack=1.
  - In range: ram_we=1, ram_addr_w=wr_addr, and the data fields are copied from the inputs.
  - Out of range: ram_we=0 and wr_err=1.
- ram_re and ram_we are never high in the same cycle. ram_we falls to 0 in the cycle after the write.
- A read of an address written in the previous cycle returns the new data, because the write has completed before the read is issued.
- Reset mid-operation:
  - Any pending rd_valid is cancelled and no stale result is emitted after reset is released.
  - Requests that are still held are re-arbitrated from pointer 0.

Test Plan:
1. After reset, voice 2 holds rd_req with rd_addr=5, and entry 5 holds {0x40,0x22,0x11} -> rd_gnt=0x04 one cycle later, ram_re=1 with addr 5, then rd_valid, rd_voice=2, left=0x11, right=0x22, factor=0x40 three cycles after the request.
2. Voices 0, 3 and 7 request simultaneously and hold until granted, pointer=0 -> grants in order 0, 3, 7 on consecutive cycles; each voice granted exactly once; rd_voice sequence 0, 3, 7.
3. wr_req to addr 9 plus four voices requesting continuously -> issue sequence W, R, R and so on, with alternation whenever the writer is pending; ram_re and ram_we are never both high; a subsequent read of entry 9 returns the written data.
4. Write to addr 61, and a voice read of addr 63 -> wr_ack with wr_err=1 and ram_we=0; the read is granted with ram_re=0 and rd_valid returns 0x00/0x00/0x00.
5. Pulse rst_n low for one cycle immediately after a read grant -> no rd_valid for that read; all outputs 0 during reset; the held request is re-granted starting the search from voice 0.
6. With VOICES=8, pointer at 7, voices 7 and 0 both request -> voice 7 is granted first, the pointer wraps, then voice 0 is granted.
